// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU result-select path.
//   - Default datapath geometry (width, number of result sources, select width).
//   - Select codes naming each ALU result source.
//   - Occupancy state encoding used by alu_mux_pipe.
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH   = 16;
    localparam int ALU_NUM_SRC = 16;
    localparam int ALU_SEL_W   = 4;

    // Result source select codes (index into the flattened din bus).
    localparam logic [ALU_SEL_W-1:0] SRC_ADD    = 4'd0;
    localparam logic [ALU_SEL_W-1:0] SRC_SUB    = 4'd1;
    localparam logic [ALU_SEL_W-1:0] SRC_AND    = 4'd2;
    localparam logic [ALU_SEL_W-1:0] SRC_OR     = 4'd3;
    localparam logic [ALU_SEL_W-1:0] SRC_XOR    = 4'd4;
    localparam logic [ALU_SEL_W-1:0] SRC_SLL    = 4'd5;
    localparam logic [ALU_SEL_W-1:0] SRC_SRL    = 4'd6;
    localparam logic [ALU_SEL_W-1:0] SRC_SRA    = 4'd7;
    localparam logic [ALU_SEL_W-1:0] SRC_SLT    = 4'd8;
    localparam logic [ALU_SEL_W-1:0] SRC_SLTU   = 4'd9;
    localparam logic [ALU_SEL_W-1:0] SRC_MUL_LO = 4'd10;
    localparam logic [ALU_SEL_W-1:0] SRC_MUL_HI = 4'd11;
    localparam logic [ALU_SEL_W-1:0] SRC_DIV    = 4'd12;
    localparam logic [ALU_SEL_W-1:0] SRC_REM    = 4'd13;
    localparam logic [ALU_SEL_W-1:0] SRC_PASS_A = 4'd14;
    localparam logic [ALU_SEL_W-1:0] SRC_PASS_B = 4'd15;

    // Number of words held by the pipe: none, y register only, y + skid.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

endpackage

// File: rtl/alu_mux_sel.sv
// ----------------------------------------------------------------------------
// alu_mux_sel
// Purely combinational indexed select: data_o = input sel_i of din_i, or zero
// when sel_i does not name an existing input (sel_i >= NUM_IN).
// Ports:
//   din_i  [NUM_IN*WIDTH-1:0]  flattened inputs, input k at din_i[k*WIDTH +: WIDTH]
//   sel_i  [SEL_W-1:0]         input index
//   data_o [WIDTH-1:0]         selected word
// ----------------------------------------------------------------------------
module alu_mux_sel
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int NUM_IN = ALU_NUM_SRC,
    parameter int SEL_W  = ALU_SEL_W
) (
    input  logic [NUM_IN*WIDTH-1:0] din_i,
    input  logic [SEL_W-1:0]        sel_i,
    output logic [WIDTH-1:0]        data_o
);

    // Compare against every legal index instead of using a variable part-select,
    // so codes past NUM_IN never address outside din_i and fall through to zero.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_i == SEL_W'(k)) begin
                data_o = din_i[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/alu_mux_pipe.sv
// ----------------------------------------------------------------------------
// alu_mux_pipe
// Registered N:1 ALU result select behind a valid/ready handshake with a
// 2-entry skid buffer (y register + skid register). Full throughput, 1-cycle
// latency, in_ready driven from registered state only.
//
// Handshake: a word moves across an interface on a rising clk edge where both
// its valid and ready are high (accept = in_valid & in_ready, transfer =
// out_valid & out_ready). Once raised, out_valid and y stay stable until the
// transfer happens.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   din        flattened inputs, input k at din[k*WIDTH +: WIDTH]
//   sel        input index, sampled on accept
//   in_valid   din/sel valid
//   in_ready   block can accept (registered)
//   y          selected word (registered)
//   out_valid  y valid
//   out_ready  consumer accepts y
//   sel_err    out-of-range select flag for the word on y
//              (only when MUX_SEL_ERR_EN is defined)
//   dbg_state  occupancy state (alu_pkg::occ_state_e encoding)
//
// Build option: `define MUX_SEL_ERR_EN adds the sel_err port and the flag that
// travels with each word through the skid path.
// ----------------------------------------------------------------------------
module alu_mux_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int NUM_IN = ALU_NUM_SRC,
    parameter int SEL_W  = ALU_SEL_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        y,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef MUX_SEL_ERR_EN
    output logic                    sel_err,
`endif
    output logic [1:0]              dbg_state
);

    logic [WIDTH-1:0] word_d;
    occ_state_e       state_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             accept;
    logic             xfer;

    alu_mux_sel #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_sel (
        .din_i  (din),
        .sel_i  (sel),
        .data_o (word_d)
    );

`ifdef MUX_SEL_ERR_EN
    // One extra bit so NUM_IN == 2**SEL_W is representable.
    localparam logic [SEL_W:0] NUM_IN_L = (SEL_W+1)'(NUM_IN);

    logic oor_d;
    logic err_q;
    logic skid_err_q;

    assign oor_d = ({1'b0, sel} >= NUM_IN_L);
`endif

    assign accept = in_valid & in_ready_q;
    assign xfer   = out_valid_q & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= OCC_EMPTY;
            y_q         <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef MUX_SEL_ERR_EN
            err_q       <= 1'b0;
            skid_err_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        y_q         <= word_d;
`ifdef MUX_SEL_ERR_EN
                        err_q       <= oor_d;
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && xfer) begin
                        y_q   <= word_d;
`ifdef MUX_SEL_ERR_EN
                        err_q <= oor_d;
`endif
                    end else if (accept) begin
                        // Consumer stalled: park the new word and stop accepting.
                        skid_q     <= word_d;
`ifdef MUX_SEL_ERR_EN
                        skid_err_q <= oor_d;
`endif
                        in_ready_q <= 1'b0;
                        state_q    <= OCC_TWO;
                    end else if (xfer) begin
                        out_valid_q <= 1'b0;
                        state_q     <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // in_ready is low here, so no accept can coincide.
                    if (xfer) begin
                        y_q        <= skid_q;
`ifdef MUX_SEL_ERR_EN
                        err_q      <= skid_err_q;
`endif
                        in_ready_q <= 1'b1;
                        state_q    <= OCC_ONE;
                    end
                end
                default: begin
                    state_q     <= OCC_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign dbg_state = state_q;
`ifdef MUX_SEL_ERR_EN
    assign sel_err   = err_q;
`endif

endmodule
